// File: rtl/ps2_rx.sv
`timescale 1ns/1ps
// PS/2 keyboard receiver: synchronizes and filters kclk, deserializes 11-bit frames,
// folds F0/E0 prefixes into is_break/is_ext and flags parity/stop/timeout errors.
//
// state  | meaning
// IDLE   | waiting for a start bit (sampled 0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then delivering or flagging
module ps2_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kclk,
    input  logic       kdata,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    kclk_sync;
    logic [1:0]    kdata_sync;
    logic          kclk_filt;
    logic          kclk_filt_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    logic          bit_in;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity;
    logic [TW-1:0] to_cnt;
    logic          break_pend;
    logic          ext_pend;
    logic          expire;

    assign fall   = kclk_filt_d & ~kclk_filt;
    assign bit_in = kdata_sync[1];
    // An edge arriving in the expiry cycle wins over the timeout.
    assign expire = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC)) && !fall;

    // Idle-bus level is 1, so synchronizers and filter preset high.
    always_ff @(posedge clk) begin
        if (rst) begin
            kclk_sync   <= 2'b11;
            kdata_sync  <= 2'b11;
            kclk_filt   <= 1'b1;
            kclk_filt_d <= 1'b1;
            filt_cnt    <= '0;
        end else begin
            kclk_sync   <= {kclk_sync[0], kclk};
            kdata_sync  <= {kdata_sync[0], kdata};
            kclk_filt_d <= kclk_filt;
            if (kclk_sync[1] == kclk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                kclk_filt <= kclk_sync[1];
                filt_cnt  <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            to_cnt     <= '0;
            break_pend <= 1'b0;
            ext_pend   <= 1'b0;
            code       <= 8'h00;
            code_valid <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == IDLE || fall)
                to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT_CYC))
                to_cnt <= to_cnt + 1'b1;

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {bit_in, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        parity <= bit_in;
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (bit_in && (^{shreg, parity})) begin
                            if (shreg == 8'hF0) begin
                                break_pend <= 1'b1;
                            end else if (shreg == 8'hE0) begin
                                ext_pend <= 1'b1;
                            end else begin
                                code       <= shreg;
                                is_break   <= break_pend;
                                is_ext     <= ext_pend;
                                code_valid <= 1'b1;
                                break_pend <= 1'b0;
                                ext_pend   <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (expire) begin
                state     <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
`timescale 1ns/1ps
// Directed bench for ps2_rx: 1 MHz clk, 80 us kclk period, short timeout for run length.
module tb_ps2_rx;
    localparam int FILTER_LEN  = 8;
    localparam int TIMEOUT_CYC = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       kclk = 1'b1;
    logic       kdata = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;

    int n_vec = 0;
    int n_err = 0;
    int n_cv = 0;
    int n_fe = 0;
    int n_both = 0;
    int cv0, fe0;

    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst(rst), .kclk(kclk), .kdata(kdata),
        .code(code), .code_valid(code_valid), .is_break(is_break),
        .is_ext(is_ext), .frame_err(frame_err)
    );

    always #500 clk = ~clk;

    // Pulse counts are in cycles, so a one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (code_valid) n_cv++;
        if (frame_err) n_fe++;
        if (code_valid && frame_err) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d);
        return {1'b1, ~^d, d, 1'b0};
    endfunction

    // Sends bits[0] first; data changes mid-high, glitch is a 7-cycle low pulse in the high phase.
    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            kdata = bits[i];
            #20_000;
            kclk = 1'b0;
            #40_000;
            kclk = 1'b1;
            if (glitch) begin
                #5_000;
                @(negedge clk) kclk = 1'b0;
                repeat (FILTER_LEN - 1) @(negedge clk);
                kclk = 1'b1;
                #5_000;
            end else begin
                #20_000;
            end
        end
        kdata = 1'b1;
        #20_000;
    endtask

    task automatic mark();
        cv0 = n_cv;
        fe0 = n_fe;
    endtask

    initial begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_code", code, 8'h00);
        check("rst_cv", code_valid, 0);
        check("rst_brk", is_break, 0);
        check("rst_ext", is_ext, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        mark();
        send_bits(frame(8'h1D), 11, 0);
        check("1d_cv", n_cv - cv0, 1);
        check("1d_code", code, 8'h1D);
        check("1d_brk", is_break, 0);
        check("1d_ext", is_ext, 0);
        check("1d_err", n_fe - fe0, 0);

        mark();
        send_bits(frame(8'hF0), 11, 0);
        check("f0_nocv", n_cv - cv0, 0);
        send_bits(frame(8'h1D), 11, 0);
        check("brk_cv", n_cv - cv0, 1);
        check("brk_code", code, 8'h1D);
        check("brk_brk", is_break, 1);
        check("brk_ext", is_ext, 0);

        mark();
        send_bits(frame(8'hE0), 11, 0);
        send_bits(frame(8'hF0), 11, 0);
        send_bits(frame(8'h75), 11, 0);
        check("e0f0_cv", n_cv - cv0, 1);
        check("e0f0_code", code, 8'h75);
        check("e0f0_ext", is_ext, 1);
        check("e0f0_brk", is_break, 1);
        send_bits(frame(8'h29), 11, 0);
        check("29_cv", n_cv - cv0, 2);
        check("29_code", code, 8'h29);
        check("29_ext", is_ext, 0);
        check("29_brk", is_break, 0);
        check("e0f0_err", n_fe - fe0, 0);

        send_bits(frame(8'h5A), 11, 0);
        check("5a_code", code, 8'h5A);
        send_bits(frame(8'hF0), 11, 0);
        mark();
        send_bits(frame(8'h29) ^ 11'h200, 11, 0);
        check("par_err", n_fe - fe0, 1);
        check("par_cv", n_cv - cv0, 0);
        check("par_code", code, 8'h5A);
        mark();
        send_bits(frame(8'h29) ^ 11'h400, 11, 0);
        check("stop_err", n_fe - fe0, 1);
        check("stop_cv", n_cv - cv0, 0);
        check("stop_code", code, 8'h5A);
        send_bits(frame(8'h1D), 11, 0);
        check("keep_code", code, 8'h1D);
        check("keep_brk", is_break, 1);
        check("keep_ext", is_ext, 0);

        send_bits(frame(8'hE0), 11, 0);
        mark();
        send_bits(frame(8'h34), 6, 0);
        repeat (TIMEOUT_CYC + 500) @(negedge clk);
        check("to_err", n_fe - fe0, 1);
        check("to_cv", n_cv - cv0, 0);
        check("to_idle", dut.state, 0);
        send_bits(frame(8'h1C), 11, 0);
        check("to_1c_cv", n_cv - cv0, 1);
        check("to_1c_code", code, 8'h1C);
        check("to_1c_ext", is_ext, 1);
        check("to_1c_err", n_fe - fe0, 1);

        mark();
        send_bits(frame(8'h23), 11, 1);
        check("gl_cv", n_cv - cv0, 1);
        check("gl_code", code, 8'h23);
        check("gl_err", n_fe - fe0, 0);

        mark();
        send_bits(frame(8'h34), 5, 0);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (TIMEOUT_CYC + 100) @(negedge clk);
        check("mr_cv", n_cv - cv0, 0);
        check("mr_err", n_fe - fe0, 0);
        check("mr_code", code, 8'h00);
        send_bits(frame(8'h4B), 11, 0);
        check("mr_4b_cv", n_cv - cv0, 1);
        check("mr_4b_code", code, 8'h4B);
        check("mr_4b_brk", is_break, 0);
        check("mr_4b_err", n_fe - fe0, 0);

        check("no_overlap", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
